// File: rtl/mem_instr_sequencer.sv
// Consumer-side fetch/decode/execute engine for the memory-interface instruction ROM.
// Drives read-strobe and lane-shift command channels and repeats the program a set number of passes.
module mem_instr_sequencer #(
    parameter int DATA_WIDTH = 56,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_LANES  = 16,
    parameter int LANE_SEL_W = 3,
    parameter int ITER_WIDTH = 16
) (
    input  logic                              CLK,
    input  logic                              RESET_N,
    input  logic                              START,
    input  logic [ITER_WIDTH-1:0]             ITERATIONS,
    output logic [ADDR_WIDTH-1:0]             ROM_ADDRESS,
    output logic                              ROM_ENABLE,
    input  logic [DATA_WIDTH-1:0]             ROM_DATA,
    input  logic                              ROM_DATA_VALID,
    output logic                              RD_VALID,
    output logic [3:0]                        RD_MASK,
    input  logic                              RD_READY,
    output logic                              SH_VALID,
    output logic [3:0]                        SH_AMOUNT,
    output logic [NUM_LANES*LANE_SEL_W-1:0]   SH_LANE_SEL,
    input  logic                              SH_READY,
    output logic                              WAITING,
    input  logic                              RESUME,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              ERR
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_RD    = 3'd4,
        S_SH    = 3'd5,
        S_WFI   = 3'd6
    } state_t;

    localparam logic [3:0] OP_READ  = 4'h0;
    localparam logic [3:0] OP_SHIFT = 4'h5;
    localparam logic [3:0] OP_WFI   = 4'h6;
    localparam logic [3:0] OP_LOOP  = 4'h7;

    localparam logic [ADDR_WIDTH-1:0] PC_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ITER_WIDTH-1:0] ITER_ONE = {{(ITER_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    err_q, err_d;
    logic                    done_d;
    logic                    rom_en_q, rd_valid_q, sh_valid_q, waiting_q, busy_q, done_q;

    // Next-state, program counter, pass counter and instruction capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iter_d  = iter_q;
        instr_d = instr_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    pc_d    = PC_ZERO;
                    iter_d  = (ITERATIONS == {ITER_WIDTH{1'b0}}) ? ITER_ONE : ITERATIONS;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (ROM_DATA_VALID) begin
                    instr_d = ROM_DATA;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EXEC: begin
                case (instr_q[7:4])
                    OP_READ:  state_d = S_RD;
                    OP_SHIFT: state_d = S_SH;
                    OP_WFI:   state_d = S_WFI;
                    OP_LOOP: begin
                        if (iter_q == ITER_ONE) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            iter_d  = iter_q - ITER_ONE;
                            pc_d    = PC_ZERO;
                            state_d = S_FETCH;
                        end
                    end
                    // Unknown opcodes flag an error and fall through as a NOP
                    default: begin
                        err_d   = 1'b1;
                        pc_d    = pc_q + PC_ONE;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_RD: begin
                if (RD_READY) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_RD;
                end
            end
            S_SH: begin
                if (SH_READY) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_SH;
                end
            end
            S_WFI: begin
                if (RESUME) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WFI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output flops; outputs follow the state being entered
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_ZERO;
            iter_q     <= {ITER_WIDTH{1'b0}};
            instr_q    <= {DATA_WIDTH{1'b0}};
            err_q      <= 1'b0;
            rom_en_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            sh_valid_q <= 1'b0;
            waiting_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iter_q     <= iter_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            rom_en_q   <= (state_d == S_FETCH);
            rd_valid_q <= (state_d == S_RD);
            sh_valid_q <= (state_d == S_SH);
            waiting_q  <= (state_d == S_WFI);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
        end
    end

    assign ROM_ADDRESS = pc_q;
    assign ROM_ENABLE  = rom_en_q;
    assign RD_VALID    = rd_valid_q;
    assign RD_MASK     = instr_q[3:0];
    assign SH_VALID    = sh_valid_q;
    assign SH_AMOUNT   = instr_q[3:0];
    assign SH_LANE_SEL = instr_q[DATA_WIDTH-1:8];
    assign WAITING     = waiting_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// Bench for mem_instr_sequencer: directed timing checks plus randomized programs scored
// against an instruction-level interpreter of the ROM program.
module tb_mem_instr_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [15:0] ITERATIONS = 16'd0;
    logic [5:0]  ROM_ADDRESS;
    logic        ROM_ENABLE;
    logic [55:0] ROM_DATA;
    logic        ROM_DATA_VALID;
    logic        RD_VALID;
    logic [3:0]  RD_MASK;
    logic        RD_READY = 1'b0;
    logic        SH_VALID;
    logic [3:0]  SH_AMOUNT;
    logic [47:0] SH_LANE_SEL;
    logic        SH_READY = 1'b0;
    logic        WAITING;
    logic        RESUME = 1'b0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    mem_instr_sequencer dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ITERATIONS(ITERATIONS),
        .ROM_ADDRESS(ROM_ADDRESS), .ROM_ENABLE(ROM_ENABLE), .ROM_DATA(ROM_DATA),
        .ROM_DATA_VALID(ROM_DATA_VALID), .RD_VALID(RD_VALID), .RD_MASK(RD_MASK),
        .RD_READY(RD_READY), .SH_VALID(SH_VALID), .SH_AMOUNT(SH_AMOUNT),
        .SH_LANE_SEL(SH_LANE_SEL), .SH_READY(SH_READY), .WAITING(WAITING),
        .RESUME(RESUME), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ROM model: one-cycle latency, optional random valid stalls; in wrap mode address 0
    // returns a loop word once it has been fetched in the current run.
    logic [55:0] rom [64];
    logic [55:0] rom_word = 56'h0;
    logic        pend = 1'b0;
    int          dv_cnt = 0;
    bit          stall_en = 1'b0;
    bit          wrap_mode = 1'b0;
    bit          seen0 = 1'b0;

    always @(posedge CLK) begin
        if (START) seen0 <= 1'b0;
        if (ROM_ENABLE) begin
            rom_word <= (wrap_mode && seen0 && ROM_ADDRESS == 6'd0) ? 56'h70 : rom[ROM_ADDRESS];
            if (ROM_ADDRESS == 6'd0) seen0 <= 1'b1;
            dv_cnt <= stall_en ? int'($urandom_range(0, 2)) : 0;
            pend   <= 1'b1;
        end else if (pend) begin
            if (dv_cnt == 0) pend <= 1'b0;
            else dv_cnt <= dv_cnt - 1;
        end
    end
    assign ROM_DATA       = rom_word;
    assign ROM_DATA_VALID = pend && (dv_cnt == 0);

    // Event monitor: fetches, completed handshakes, wfi releases, done pulses
    logic [63:0] act_q[$];
    int          done_cnt = 0;
    always @(negedge CLK) begin
        if (ROM_ENABLE) act_q.push_back({4'd1, 54'd0, ROM_ADDRESS});
        if (RD_VALID && RD_READY) act_q.push_back({4'd2, 56'd0, RD_MASK});
        if (SH_VALID && SH_READY) act_q.push_back({4'd3, 8'd0, SH_LANE_SEL, SH_AMOUNT});
        if (WAITING && RESUME) act_q.push_back({4'd4, 60'd0});
        if (DONE) begin
            act_q.push_back({4'd5, 60'd0});
            done_cnt <= done_cnt + 1;
        end
    end

    // Reference interpreter of the program at instruction level
    logic [63:0] exp_q[$];
    task automatic model(input logic [15:0] iters, input bit wrap, output bit err);
        logic [5:0]  pc;
        logic [55:0] w;
        int          it;
        bit          s0;
        exp_q.delete();
        pc = 6'd0; s0 = 1'b0; err = 1'b0;
        it = (iters == 16'd0) ? 1 : int'(iters);
        for (int n = 0; n < 5000; n++) begin
            exp_q.push_back({4'd1, 54'd0, pc});
            w = (wrap && s0 && pc == 6'd0) ? 56'h70 : rom[pc];
            if (pc == 6'd0) s0 = 1'b1;
            case (w[7:4])
                4'h0: begin exp_q.push_back({4'd2, 56'd0, w[3:0]}); pc = pc + 6'd1; end
                4'h5: begin exp_q.push_back({4'd3, 8'd0, w[55:8], w[3:0]}); pc = pc + 6'd1; end
                4'h6: begin exp_q.push_back({4'd4, 60'd0}); pc = pc + 6'd1; end
                4'h7: begin
                    if (it == 1) begin
                        exp_q.push_back({4'd5, 60'd0});
                        break;
                    end
                    it = it - 1;
                    pc = 6'd0;
                end
                default: begin err = 1'b1; pc = pc + 6'd1; end
            endcase
        end
    endtask

    function automatic logic [55:0] gen_word(input bit allow_loop);
        logic [63:0] rr;
        logic [3:0]  op;
        int          r;
        rr = {$urandom, $urandom};
        r  = int'($urandom_range(0, 9));
        if (r < 3) op = 4'h0;
        else if (r < 6) op = 4'h5;
        else if (r < 8) op = 4'h6;
        else if (r == 8) op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(8, 15));
        else op = allow_loop ? 4'h7 : 4'h0;
        return {rr[47:0], op, 4'($urandom_range(0, 15))};
    endfunction

    function automatic logic sigval(input int sel);
        case (sel)
            0: return ROM_ENABLE;
            1: return RD_VALID;
            2: return SH_VALID;
            3: return WAITING;
            4: return DONE;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (!sigval(sel) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check_val(tag, 64'(sigval(sel)), 64'd1);
    endtask

    task automatic start_prog(input logic [15:0] iters);
        @(posedge CLK); #1;
        ITERATIONS = iters;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic run_random(input logic [15:0] iters, input bit wrap, input string tag);
        int base, d0, m;
        bit exp_err;
        base = act_q.size();
        d0   = done_cnt;
        stall_en = 1'b1;
        wrap_mode = wrap;
        RD_READY = 1'b1; SH_READY = 1'b1; RESUME = 1'b0;
        start_prog(iters);
        for (int c = 0; c < 6000 && done_cnt == d0; c++) begin
            @(posedge CLK); #1;
            RD_READY = ($urandom_range(0, 2) != 0);
            SH_READY = ($urandom_range(0, 2) != 0);
            RESUME   = ($urandom_range(0, 3) == 0);
        end
        check_val({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        repeat (2) @(posedge CLK);
        #1;
        model(iters, wrap, exp_err);
        check_val({tag, "_nevt"}, 64'(act_q.size() - base), 64'(exp_q.size()));
        m = (act_q.size() - base < exp_q.size()) ? act_q.size() - base : exp_q.size();
        for (int i = 0; i < m; i++) check_val({tag, "_evt"}, act_q[base + i], exp_q[i]);
        check_val({tag, "_err"}, 64'(ERR), 64'(exp_err));
        check_val({tag, "_busy"}, 64'(BUSY), 64'd0);
        wrap_mode = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 64; a++) rom[a] = 56'h70;
        #2;
        check_val("reset_outs", 64'({ROM_ADDRESS, ROM_ENABLE, RD_VALID, RD_MASK, SH_VALID,
                  SH_AMOUNT, WAITING, BUSY, DONE, ERR}), 64'd0);
        check_val("reset_lanes", 64'(SH_LANE_SEL), 64'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // Directed: read, backpressured shift, wfi, single pass
        rom[0] = 56'h1;
        rom[1] = {33'd0, 12'o4444, 3'd0, 8'h5F};
        rom[2] = 56'h60;
        rom[3] = 56'h70;
        RD_READY = 1'b1; SH_READY = 1'b0; RESUME = 1'b0;
        start_prog(16'd1);
        wait_for(0, "fetch0");
        check_val("fetch0_addr", 64'(ROM_ADDRESS), 64'd0);
        @(negedge CLK);
        check_val("fetch_1cyc", 64'(ROM_ENABLE), 64'd0);
        @(negedge CLK);
        check_val("exec_no_rd", 64'(RD_VALID), 64'd0);
        @(negedge CLK);
        check_val("rd_valid", 64'(RD_VALID), 64'd1);
        check_val("rd_mask", 64'(RD_MASK), 64'd1);
        @(negedge CLK);
        check_val("rd_drop", 64'(RD_VALID), 64'd0);
        check_val("fetch1_en", 64'(ROM_ENABLE), 64'd1);
        check_val("fetch1_addr", 64'(ROM_ADDRESS), 64'd1);

        wait_for(2, "sh_valid");
        for (int k = 0; k < 6; k++) begin
            check_val("sh_held", 64'(SH_VALID), 64'd1);
            check_val("sh_amount", 64'(SH_AMOUNT), 64'd15);
            check_val("sh_lanes", 64'(SH_LANE_SEL), 64'({33'd0, 12'o4444, 3'd0}));
            @(posedge CLK); #1;
            if (k == 4) SH_READY = 1'b1;
            @(negedge CLK);
        end
        check_val("sh_drop", 64'(SH_VALID), 64'd0);
        check_val("fetch2_addr", 64'({ROM_ENABLE, ROM_ADDRESS}), 64'({1'b1, 6'd2}));

        wait_for(3, "wfi_enter");
        for (int k = 0; k < 10; k++) begin
            check_val("wfi_waiting", 64'(WAITING), 64'd1);
            check_val("wfi_no_fetch", 64'(ROM_ENABLE), 64'd0);
            @(posedge CLK); #1;
            START = (k == 2);
            if (k == 8) RESUME = 1'b1;
            @(negedge CLK);
        end
        check_val("wfi_exit", 64'(WAITING), 64'd0);
        check_val("fetch3_addr", 64'({ROM_ENABLE, ROM_ADDRESS}), 64'({1'b1, 6'd3}));
        RESUME = 1'b0;
        wait_for(4, "done_pulse");
        check_val("done_busy", 64'(BUSY), 64'd0);
        @(negedge CLK);
        check_val("done_1cyc", 64'(DONE), 64'd0);
        check_val("idle_err", 64'({BUSY, ERR}), 64'd0);

        // Async reset in the middle of a stalled shift handshake
        rom[0] = {33'd0, 12'o4444, 3'd0, 8'h53};
        SH_READY = 1'b0;
        start_prog(16'd1);
        wait_for(2, "rst_sh_valid");
        #2;
        RESET_N = 1'b0;
        #1;
        check_val("rst_sh_drop", 64'(SH_VALID), 64'd0);
        check_val("rst_outs", 64'({ROM_ADDRESS, ROM_ENABLE, RD_VALID, RD_MASK, SH_VALID,
                  SH_AMOUNT, WAITING, BUSY, DONE, ERR}), 64'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // Randomized programs; every pass count 0..3 appears twice
        for (int r = 0; r < 8; r++) begin
            int len;
            len = int'($urandom_range(1, 20));
            for (int a = 0; a < 64; a++) rom[a] = (a < len) ? gen_word(1'b1) : 56'h70;
            run_random(16'(r % 4), 1'b0, "rand");
        end

        // Full-length program: illegal at 5, PC wraps 63 -> 0
        for (int a = 0; a < 64; a++) rom[a] = gen_word(1'b0);
        rom[5] = 56'hF0;
        run_random(16'd2, 1'b1, "wrap");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
